oam_dma_engine: RTL and testbench

// - OAM DMA controller behind register 0xFF46, next to MemMap in the memory subsystem.
// - A CPU write to 0xFF46 copies XFER_LEN bytes from {base,8'h00} into OAM (0xFE00+), one byte per M-cycle.
// - MemMap forwards the 0xFF46 write strobe and serves the source reads.
// - active_out lets MemMap restrict CPU access to HRAM while the copy runs.

---
 rtl/oam_dma_engine.sv | 122 ++++++++++++
 tb/tb_oam_dma_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// OAM DMA controller: copies XFER_LEN bytes from {page,8'h00} into OAM, one byte per M-cycle.
// Optional feature: define DMA_SRC_MIRROR_EN to map source pages 0xE0..0xFF onto 0xC0..0xDF.
module oam_dma_engine #(
  parameter int unsigned XFER_LEN    = 160,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mclock_in,
  input  logic        reg_wr_in,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  dma_reg_out,
  output logic        busy_out,
  output logic        active_out,
  output logic        src_rd_out,
  output logic [15:0] src_addr_out,
  input  logic [7:0]  src_data_in,
  output logic        oam_wr_out,
  output logic [7:0]  oam_addr_out,
  output logic [7:0]  oam_data_out
);

  typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

  localparam logic [7:0] LastIdx  = 8'(XFER_LEN - 1);
  localparam int unsigned LastDlyI = (START_DELAY == 0) ? 0 : START_DELAY - 1;
  localparam logic [1:0] LastDly  = 2'(LastDlyI);
  // With no start delay a write goes straight to the copy phase.
  localparam state_e     EntrySt  = (START_DELAY == 0) ? StXfer : StStart;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic        oam_wr_q, oam_wr_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;
  logic [7:0]  page_eff;

`ifdef DMA_SRC_MIRROR_EN
  assign page_eff = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
`else
  assign page_eff = page_q;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      page_q     <= 8'h00;
      dma_reg_q  <= 8'h00;
      idx_q      <= 8'h00;
      dcnt_q     <= 2'd0;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      dma_reg_q  <= dma_reg_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      oam_wr_q   <= oam_wr_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    dma_reg_d  = dma_reg_q;
    idx_d      = idx_q;
    dcnt_d     = dcnt_q;
    oam_wr_d   = 1'b0;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;
    // A register write (re)starts the transfer in any state and beats a coincident tick.
    if (reg_wr_in) begin
      page_d    = reg_data_in;
      dma_reg_d = reg_data_in;
      idx_d     = 8'h00;
      dcnt_d    = 2'd0;
      state_d   = EntrySt;
    end else begin
      unique case (state_q)
        StStart: begin
          if (mclock_in) begin
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == LastDly) begin
              state_d = StXfer;
            end
          end
        end
        StXfer: begin
          if (mclock_in) begin
            oam_wr_d   = 1'b1;
            oam_addr_d = idx_q;
            oam_data_d = src_data_in;
            if (idx_q == LastIdx) begin
              idx_d   = 8'h00;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dma_reg_out  = dma_reg_q;
  assign busy_out     = (state_q != StIdle);
  assign active_out   = (state_q == StXfer);
  assign src_rd_out   = active_out;
  assign src_addr_out = active_out ? {page_eff, idx_q} : 16'h0000;
  assign oam_wr_out   = oam_wr_q;
  assign oam_addr_out = oam_addr_q;
  assign oam_data_out = oam_data_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: source-memory model plus a scoreboard of expected OAM writes.
module tb_oam_dma_engine;

  localparam int XferLen = 160;

  logic        clk_in;
  logic        rst_in;
  logic        mclock_in;
  logic        reg_wr_in;
  logic [7:0]  reg_data_in;
  logic [7:0]  dma_reg_out;
  logic        busy_out;
  logic        active_out;
  logic        src_rd_out;
  logic [15:0] src_addr_out;
  logic [7:0]  src_data_in;
  logic        oam_wr_out;
  logic [7:0]  oam_addr_out;
  logic [7:0]  oam_data_out;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int mclk_cnt = 0;
  logic [15:0] exp_q[$];

  oam_dma_engine dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mclock_in    (mclock_in),
    .reg_wr_in    (reg_wr_in),
    .reg_data_in  (reg_data_in),
    .dma_reg_out  (dma_reg_out),
    .busy_out     (busy_out),
    .active_out   (active_out),
    .src_rd_out   (src_rd_out),
    .src_addr_out (src_addr_out),
    .src_data_in  (src_data_in),
    .oam_wr_out   (oam_wr_out),
    .oam_addr_out (oam_addr_out),
    .oam_data_out (oam_data_out)
  );

  function automatic logic [7:0] mem(input logic [15:0] a);
    return {a[6:0], a[7]} ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] eff_page(input logic [7:0] p);
`ifdef DMA_SRC_MIRROR_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  assign src_data_in = mem(src_addr_out);

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // One-clock M-cycle tick every fourth clock, driven shortly after the rising edge.
  initial begin
    mclock_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      mclk_cnt++;
      mclock_in = (mclk_cnt % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_xfer(input logic [7:0] page);
    exp_q.delete();
    for (int i = 0; i < XferLen; i++) begin
      exp_q.push_back({i[7:0], mem({eff_page(page), i[7:0]})});
    end
  endtask

  always @(negedge clk_in) begin
    if (oam_wr_out) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_oam_write", {oam_addr_out, oam_data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("oam_write", {16'h0, oam_addr_out, oam_data_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Register write on a clock that does not carry an M-cycle tick.
  task automatic wr(input logic [7:0] d);
    @(posedge clk_in); #2;
    while (mclock_in) begin
      @(posedge clk_in); #2;
    end
    reg_wr_in = 1'b1;
    reg_data_in = d;
    @(posedge clk_in); #2;
    reg_wr_in = 1'b0;
  endtask

  // Register write landing on the same clock as an M-cycle tick.
  task automatic wr_tick(input logic [7:0] d);
    @(posedge clk_in); #2;
    while (!mclock_in) begin
      @(posedge clk_in); #2;
    end
    reg_wr_in = 1'b1;
    reg_data_in = d;
    @(posedge clk_in); #2;
    reg_wr_in = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    int budget = 3000;
    while (k < n && budget > 0) begin
      @(negedge clk_in);
      budget--;
      if (oam_wr_out) k++;
    end
    if (k < n) chk({tag, "_timeout"}, k, n);
  endtask

  task automatic wait_active(input string tag);
    int budget = 100;
    @(negedge clk_in);
    while (!active_out && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    if (!active_out) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_active"}, active_out, 0);
    chk({tag, "_src_rd"}, src_rd_out, 0);
    chk({tag, "_src_addr"}, src_addr_out, 0);
    chk({tag, "_oam_wr"}, oam_wr_out, 0);
    chk({tag, "_oam_addr"}, oam_addr_out, 0);
    chk({tag, "_oam_data"}, oam_data_out, 0);
    chk({tag, "_dma_reg"}, dma_reg_out, 0);
  endtask

  initial begin
    int snap;
    rst_in = 1'b0;
    reg_wr_in = 1'b0;
    reg_data_in = 8'h00;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b1;

    // Basic transfer from page C1.
    wr_cnt = 0;
    push_xfer(8'hC1);
    wr(8'hC1);
    @(negedge clk_in);
    chk("c1_start_busy", busy_out, 1);
    chk("c1_start_active", active_out, 0);
    chk("c1_start_src_rd", src_rd_out, 0);
    wait_active("c1_active");
    chk("c1_first_addr", src_addr_out, 16'hC100);
    chk("c1_src_rd", src_rd_out, 1);
    wait_writes(XferLen, "c1_writes");
    chk("c1_busy_after_last", busy_out, 0);
    chk("c1_active_after_last", active_out, 0);
    repeat (8) @(negedge clk_in);
    chk("c1_total_writes", wr_cnt, XferLen);
    chk("c1_queue_empty", exp_q.size(), 0);

    // Restart mid-copy: C0 then D0 after 50 writes.
    wr_cnt = 0;
    push_xfer(8'hC0);
    wr(8'hC0);
    wait_writes(50, "restart_first");
    wr(8'hD0);
    push_xfer(8'hD0);
    @(negedge clk_in);
    chk("restart_busy", busy_out, 1);
    chk("restart_active", active_out, 0);
    chk("restart_dma_reg", dma_reg_out, 8'hD0);
    wait_writes(XferLen, "restart_second");
    repeat (8) @(negedge clk_in);
    chk("restart_total_writes", wr_cnt, 50 + XferLen);
    chk("restart_queue_empty", exp_q.size(), 0);

    // Restart coinciding with a tick suppresses that tick's write.
    push_xfer(8'hC2);
    wr(8'hC2);
    wait_writes(20, "coinc_first");
    wr_tick(8'hC3);
    push_xfer(8'hC3);
    @(negedge clk_in);
    chk("coinc_no_write", oam_wr_out, 0);
    wait_active("coinc_active");
    chk("coinc_first_addr", src_addr_out, 16'hC300);
    wait_writes(XferLen, "coinc_second");
    repeat (8) @(negedge clk_in);
    chk("coinc_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-transfer.
    push_xfer(8'hC4);
    wr(8'hC4);
    wait_writes(80, "rst_pre");
    #1 rst_in = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    snap = wr_cnt;
    repeat (40) @(negedge clk_in);
    chk("rst_no_writes", wr_cnt, snap);
    chk("rst_dma_reg", dma_reg_out, 8'h00);
    chk("rst_busy", busy_out, 0);
    push_xfer(8'hC5);
    wr(8'hC5);
    wait_active("rst_new_active");
    chk("rst_new_addr", src_addr_out, 16'hC500);
    wait_writes(XferLen, "rst_new");
    repeat (8) @(negedge clk_in);
    chk("rst_new_queue_empty", exp_q.size(), 0);

    // Echo page source address.
    push_xfer(8'hFE);
    wr(8'hFE);
    wait_active("fe_active");
    chk("fe_first_addr", src_addr_out, {eff_page(8'hFE), 8'h00});
    chk("fe_dma_reg", dma_reg_out, 8'hFE);
    wait_writes(XferLen, "fe");
    repeat (8) @(negedge clk_in);
    chk("fe_queue_empty", exp_q.size(), 0);

    // Readback through a full transfer.
    push_xfer(8'h83);
    wr(8'h83);
    @(negedge clk_in);
    chk("rb_start_dma_reg", dma_reg_out, 8'h83);
    chk("rb_start_active", active_out, 0);
    chk("rb_start_busy", busy_out, 1);
    wait_active("rb_active");
    chk("rb_xfer_dma_reg", dma_reg_out, 8'h83);
    chk("rb_first_addr", src_addr_out, 16'h8300);
    wait_writes(XferLen, "rb");
    repeat (8) @(negedge clk_in);
    chk("rb_after_dma_reg", dma_reg_out, 8'h83);
    chk("rb_after_busy", busy_out, 0);
    chk("rb_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
